// File: rtl/ps2_frame_controller.sv
// PS/2 receive frame sequencer: detects PS/2 clock falls, assembles and validates
// 11-bit frames, tracks E0/F0 prefixes and hands scan codes out via valid/ack.
module ps2_frame_controller #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int CNT_W          = 16
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       DEBOUNCED_DATA,
  input  logic       DEBOUNCED_SLOW_CLOCK,
  input  logic       SCAN_ACK,
  output logic [7:0] SCAN_CODE,
  output logic       EXTENDED,
  output logic       RELEASE,
  output logic       SCAN_VALID,
  output logic       OVERRUN,
  output logic       FRAME_ERROR,
  output logic [1:0] ERROR_CODE
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;

  // Counter stops one short so the error lands TIMEOUT_CYCLES-1 CLKs after the last fall
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       state;
  logic             prev_ps2clk;
  logic [3:0]       bit_cnt;
  logic [9:0]       shift_reg;  // {stop, parity, data[7:0]} once full
  logic [CNT_W-1:0] tcnt;
  logic             ext_flag;
  logic             rel_flag;
  logic             fall;
  logic             stop_bad;
  logic             parity_bad;
  logic [7:0]       rx_byte;

  assign fall       = prev_ps2clk & ~DEBOUNCED_SLOW_CLOCK;
  assign rx_byte    = shift_reg[7:0];
  assign stop_bad   = ~shift_reg[9];
  assign parity_bad = ~(^shift_reg[8:0]);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= IDLE;
      prev_ps2clk <= 1'b1;
      bit_cnt     <= 4'd0;
      shift_reg   <= 10'd0;
      tcnt        <= '0;
      ext_flag    <= 1'b0;
      rel_flag    <= 1'b0;
      SCAN_CODE   <= 8'h00;
      EXTENDED    <= 1'b0;
      RELEASE     <= 1'b0;
      SCAN_VALID  <= 1'b0;
      OVERRUN     <= 1'b0;
      FRAME_ERROR <= 1'b0;
      ERROR_CODE  <= 2'b00;
    end else begin
      prev_ps2clk <= DEBOUNCED_SLOW_CLOCK;
      OVERRUN     <= 1'b0;
      FRAME_ERROR <= 1'b0;
      if (SCAN_VALID && SCAN_ACK) SCAN_VALID <= 1'b0;

      case (state)
        IDLE: begin
          if (fall && !DEBOUNCED_DATA) begin
            state   <= SHIFT;
            bit_cnt <= 4'd1;
            tcnt    <= '0;
          end
        end
        SHIFT: begin
          if (fall) begin
            shift_reg <= {DEBOUNCED_DATA, shift_reg[9:1]};
            bit_cnt   <= bit_cnt + 4'd1;
            tcnt      <= '0;
            if (bit_cnt == 4'd10) state <= CHECK;
          end else if (tcnt == TO_LAST) begin
            state       <= IDLE;
            FRAME_ERROR <= 1'b1;
            ERROR_CODE  <= 2'b11;
            ext_flag    <= 1'b0;
            rel_flag    <= 1'b0;
          end else begin
            tcnt <= tcnt + CNT_ONE;
          end
        end
        CHECK: begin
          state <= IDLE;
          if (stop_bad || parity_bad) begin
            FRAME_ERROR <= 1'b1;
            ERROR_CODE  <= stop_bad ? 2'b10 : 2'b01;
            ext_flag    <= 1'b0;
            rel_flag    <= 1'b0;
          end else if (rx_byte == 8'hE0) begin
            ext_flag <= 1'b1;
          end else if (rx_byte == 8'hF0) begin
            rel_flag <= 1'b1;
          end else begin
            ext_flag <= 1'b0;
            rel_flag <= 1'b0;
            // An ack on this edge frees the register, so the new code takes its place
            if (!SCAN_VALID || SCAN_ACK) begin
              SCAN_CODE  <= rx_byte;
              EXTENDED   <= ext_flag;
              RELEASE    <= rel_flag;
              SCAN_VALID <= 1'b1;
            end else begin
              OVERRUN <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_frame_controller.sv
// Directed bench for ps2_frame_controller with hand-computed expectations.
module tb_ps2_frame_controller;
  localparam int TO = 40;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ps2d, ps2c, ack;
  logic [7:0] scan_code;
  logic       extended, release_o, scan_valid, overrun, frame_error;
  logic [1:0] error_code;
  int         n_chk = 0;
  int         n_fail = 0;
  logic       cap_vld;

  ps2_frame_controller #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
    .CLK(clk), .RESET_N(rst_n), .DEBOUNCED_DATA(ps2d), .DEBOUNCED_SLOW_CLOCK(ps2c),
    .SCAN_ACK(ack), .SCAN_CODE(scan_code), .EXTENDED(extended), .RELEASE(release_o),
    .SCAN_VALID(scan_valid), .OVERRUN(overrun), .FRAME_ERROR(frame_error),
    .ERROR_CODE(error_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One PS/2 bit: clock high with data set, then clock dropped on a negedge;
  // the capture (FALL) edge is the next posedge after return.
  task automatic send_bit(input logic b);
    @(negedge clk); ps2c = 1'b1; ps2d = b;
    repeat (3) @(negedge clk);
    ps2c = 1'b0;
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) send_bit(bits[i]);
  endtask

  // Full frame; returns just after the CHECK edge so pulses are observable.
  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop_b,
                            input logic ack_chk);
    logic par;
    par = ~(^d) ^ bad_par;
    send_bits({stop_b, par, d, 1'b0}, 11);
    @(posedge clk); #1;
    cap_vld = scan_valid;
    if (ack_chk) ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
  endtask

  task automatic do_ack();
    @(negedge clk); ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    chk("ack_clears_valid", scan_valid, 0);
  endtask

  initial begin
    rst_n = 1'b0; ps2d = 1'b1; ps2c = 1'b1; ack = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_valid", scan_valid, 0);
    chk("rst_code", scan_code, 8'h00);
    chk("rst_errcode", error_code, 2'b00);
    chk("rst_pulses", {overrun, frame_error, extended, release_o}, 0);
    @(negedge clk); rst_n = 1'b1;

    // Plain 1C: valid appears one edge after stop capture and holds until ack
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    chk("1c_valid_at_capture", cap_vld, 0);
    chk("1c_valid", scan_valid, 1);
    chk("1c_code", scan_code, 8'h1C);
    chk("1c_ext_rel", {extended, release_o}, 2'b00);
    chk("1c_no_err", {frame_error, overrun}, 2'b00);
    repeat (5) @(posedge clk); #1;
    chk("1c_hold_valid", scan_valid, 1);
    chk("1c_hold_code", scan_code, 8'h1C);
    do_ack();

    // F0 1C -> release
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    chk("f0_no_valid", scan_valid, 0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    chk("rel_valid", scan_valid, 1);
    chk("rel_code", scan_code, 8'h1C);
    chk("rel_flags", {extended, release_o}, 2'b01);
    do_ack();

    // E0 F0 75 -> extended release, then flags clear for 1C
    send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    chk("e0f0_no_valid", scan_valid, 0);
    send_frame(8'h75, 1'b0, 1'b1, 1'b0);
    chk("extrel_code", scan_code, 8'h75);
    chk("extrel_flags", {extended, release_o}, 2'b11);
    do_ack();
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    chk("flags_cleared", {extended, release_o}, 2'b00);
    do_ack();

    // Parity and stop errors
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    chk("par_ferr", frame_error, 1);
    chk("par_code", error_code, 2'b01);
    chk("par_no_valid", scan_valid, 0);
    @(posedge clk); #1;
    chk("par_ferr_width", frame_error, 0);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    chk("stop_ferr", frame_error, 1);
    chk("stop_code", error_code, 2'b10);
    chk("stop_no_valid", scan_valid, 0);

    // Timeout after 5 falls; E0 before it must be forgotten
    send_frame(8'hE0, 1'b0, 1'b1, 1'b0);
    send_bits(11'b000_0101_0100, 5);
    @(posedge clk); #1;
    repeat (TO - 2) @(posedge clk); #1;
    chk("to_not_early", frame_error, 0);
    @(posedge clk); #1;
    chk("to_ferr", frame_error, 1);
    chk("to_code", error_code, 2'b11);
    send_frame(8'h2A, 1'b0, 1'b1, 1'b0);
    chk("after_to_valid", scan_valid, 1);
    chk("after_to_code", scan_code, 8'h2A);
    chk("after_to_flags", {extended, release_o}, 2'b00);
    do_ack();

    // Overrun, then ack on the CHECK edge replaces without overrun
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    send_frame(8'h32, 1'b0, 1'b1, 1'b0);
    chk("ovr_pulse", overrun, 1);
    chk("ovr_keep_code", scan_code, 8'h1C);
    chk("ovr_keep_valid", scan_valid, 1);
    @(posedge clk); #1;
    chk("ovr_width", overrun, 0);
    send_frame(8'h32, 1'b0, 1'b1, 1'b1);
    chk("ackchk_no_ovr", overrun, 0);
    chk("ackchk_valid", scan_valid, 1);
    chk("ackchk_code", scan_code, 8'h32);

    // Reset after 6 bits of a frame while the register is full
    send_bits({1'b1, 1'b1, 8'h5A, 1'b0}, 6);
    @(negedge clk); rst_n = 1'b0; ps2c = 1'b1; ps2d = 1'b1;
    #1;
    chk("mid_rst_valid", scan_valid, 0);
    chk("mid_rst_code", scan_code, 8'h00);
    chk("mid_rst_errcode", error_code, 2'b00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    chk("post_rst_valid", scan_valid, 1);
    chk("post_rst_code", scan_code, 8'h1C);
    chk("post_rst_flags", {extended, release_o, frame_error}, 3'b000);
    do_ack();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ps2_frame_controller.md
# ps2_frame_controller

Frame sequencer for the PS/2 keyboard path. It consumes the synchronized, debounced PS/2 data and clock lines and detects falling edges of the PS/2 clock in the fast system clock domain. It steps through the 11-bit frame (start, 8 data LSB first, odd parity, stop), validates it, and tracks E0/F0 prefix bytes. It hands complete scan codes to the consumer through a one-entry valid/ack holding register with overrun and error reporting.

## Interface
- TIMEOUT_CYCLES, 50000: max CLK cycles between PS/2 falling edges inside a frame (1 ms at 50 MHz).
- CNT_W, 16: width of the timeout counter; must hold TIMEOUT_CYCLES-1.

- CLK  input  1  fast system clock; all logic on its rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- DEBOUNCED_DATA  input  1  synchronized PS/2 data, already in CLK domain.
- DEBOUNCED_SLOW_CLOCK  input  1  synchronized PS/2 clock, already in CLK domain.
- SCAN_ACK  input  1  consumer accepts SCAN_CODE when high with SCAN_VALID.
- SCAN_CODE  output  8  last accepted scan code byte (never E0/F0).
- EXTENDED  output  1  SCAN_CODE was preceded by E0.
- RELEASE  output  1  SCAN_CODE was preceded by F0.
- SCAN_VALID  output  1  holding register full.
- OVERRUN  output  1  one-cycle pulse: a good code was dropped because the register was full.
- FRAME_ERROR  output  1  one-cycle pulse: frame rejected.
- ERROR_CODE  output  2  cause of last FRAME_ERROR: 01 parity, 10 stop bit, 11 timeout; holds until the next error.

## Operation
- Edge detect: register PREV_PS2CLK, which resets to 1. FALL = PREV_PS2CLK & ~DEBOUNCED_SLOW_CLOCK.
- States:
  - IDLE: FALL with DATA=0 → SHIFT, bit count=1, timeout counter cleared. FALL with DATA=1 is ignored.
  - SHIFT: each FALL shifts DATA into a 10-bit register (data[7:0], parity, stop), increments the bit count and clears the timeout counter. The FALL that captures bit 10 (stop) → CHECK.
  - CHECK: one cycle, then → IDLE.
- Timeout: in SHIFT the counter increments every CLK without FALL. On reaching TIMEOUT_CYCLES-1: → IDLE, FRAME_ERROR pulse, ERROR_CODE=11, prefix flags cleared.
- CHECK evaluation, in priority order:
  - Stop bit=0 → error, code 10.
  - Else XOR of data[7:0] and parity ≠ 1 → error, code 01.
  - Either error: FRAME_ERROR pulse, prefix flags cleared, nothing loaded.
  - Good byte E0: set EXT flag, no output.
  - Good byte F0: set REL flag, no output.
  - Other good byte: if register empty or SCAN_ACK high this cycle, load SCAN_CODE, EXTENDED=EXT flag, RELEASE=REL flag, SCAN_VALID=1. Otherwise OVERRUN pulse and the old contents are kept. Both flags are cleared in either case.
- Handshake:
  - SCAN_VALID stays high until a CLK edge with SCAN_ACK=1. It then clears, unless CHECK loads on that same edge; in that case it stays 1 with the new data and no overrun.
  - SCAN_CODE, EXTENDED and RELEASE are stable while SCAN_VALID=1.
  - SCAN_ACK with SCAN_VALID=0 is ignored.

## Timing
- Reset values: state IDLE, SCAN_CODE=00, EXTENDED=0, RELEASE=0, SCAN_VALID=0, OVERRUN=0, FRAME_ERROR=0, ERROR_CODE=00, flags 0, counters 0, PREV_PS2CLK=1.
- Reset is asynchronous and may arrive mid-frame; the partial frame is discarded. The first FALL after release is accepted only as a start bit.
- Bit capture happens on the CLK edge where FALL is true (DATA sampled on that same edge).
- SCAN_VALID, OVERRUN and FRAME_ERROR (stop/parity) assert on the edge 1 CLK after the stop-bit capture edge.
- Timeout FRAME_ERROR asserts TIMEOUT_CYCLES-1 CLKs after the last FALL.
- OVERRUN and FRAME_ERROR are exactly 1 CLK wide.
- A FALL during CHECK is impossible at PS/2 rates and need not be handled.

## Test plan
- Frame 0x1C (start 0, data 0,0,1,1,1,0,0,0, parity 0, stop 1) → SCAN_CODE=1C, EXTENDED=0, RELEASE=0, SCAN_VALID high 1 CLK after stop capture; holds until SCAN_ACK, clears next edge.
- Frames F0 then 1C → single SCAN_VALID with 1C and RELEASE=1. Frames E0, F0, 75 → 75 with EXTENDED=1 and RELEASE=1; the flags are clear for the following code.
- Frame 0x1C with parity bit 1 → FRAME_ERROR pulse, ERROR_CODE=01, SCAN_VALID stays 0. Stop bit 0 → ERROR_CODE=10.
- Stop PS/2 clock after 5 falls → FRAME_ERROR and ERROR_CODE=11 at TIMEOUT_CYCLES-1 CLKs. A following valid 0x2A frame is received correctly.
- Send 1C without ACK, then 32 → OVERRUN pulse, SCAN_CODE stays 1C. Repeat with ACK on the CHECK edge → SCAN_CODE=32, no OVERRUN.
- Assert RESET_N low after 6 bits of a frame → all outputs reset values. A subsequent full 0x1C frame is decoded.
